// File: rtl/umem_arb_pkg.sv
// umem_arb_pkg: shared state and access-size types for the unified memory arbiter
package umem_arb_pkg;
  typedef enum logic {IDLE, ISSUE} state_t;
  typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2} size_t;
endpackage

// File: rtl/umem_arb_rr.sv
// umem_arb_rr: two-way round-robin picker; last is the index granted most recently
module umem_arb_rr (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);
  assign grant = {req[1] & (~req[0] | ~last), req[0] & (~req[1] | last)};
endmodule

// File: rtl/umem_arb.sv
// umem_arb: two-requester memory arbiter; define UMEM_ARB_TIMEOUT_EN to abort stalled accesses after TIMEOUT cycles
module umem_arb
  import umem_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          r0_req,
  input  logic          r0_rw,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  input  logic [1:0]    r0_size,
  output logic          r0_gnt,
  output logic          r0_done,
  output logic          r0_err,
  input  logic          r1_req,
  input  logic          r1_rw,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  input  logic [1:0]    r1_size,
  output logic          r1_gnt,
  output logic          r1_done,
  output logic          r1_err,
  output logic [DW-1:0] rdata,
  output logic          mem_req,
  output logic          mem_rw,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [1:0]    mem_size,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata
);
  state_t        r_state;
  logic [1:0]    r_gnt, r_done, w_gnt;
  logic          r_owner, r_last, r_mem_req, r_rw;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata, r_rdata;
  size_t         r_size;
  umem_arb_rr u_rr (.req({r1_req, r0_req}), .last(r_last), .grant(w_gnt));
  assign {r1_gnt, r0_gnt}   = r_gnt;
  assign {r1_done, r0_done} = r_done;
  assign rdata     = r_rdata;
  assign mem_req   = r_mem_req;
  assign mem_rw    = r_rw;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_size  = r_size;
`ifdef UMEM_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0] r_cnt;
  logic          r_err;
  assign r0_err = r_err & r_done[0];
  assign r1_err = r_err & r_done[1];
`else
  assign r0_err = 1'b0;
  assign r1_err = 1'b0;
`endif
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state   <= IDLE;
      r_gnt     <= '0;
      r_done    <= '0;
      r_owner   <= 1'b0;
      r_last    <= 1'b1;
      r_mem_req <= 1'b0;
      r_rw      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_size    <= SZ_B;
      r_rdata   <= '0;
`ifdef UMEM_ARB_TIMEOUT_EN
      r_cnt     <= '0;
      r_err     <= 1'b0;
`endif
    end else begin
      r_gnt  <= '0;
      r_done <= '0;
`ifdef UMEM_ARB_TIMEOUT_EN
      r_err  <= 1'b0;
`endif
      // a requester still sees its own done this cycle, so hold off one cycle before regranting
      if (r_state == IDLE) begin
        if (|w_gnt && !(|r_done)) begin
          r_gnt   <= w_gnt;
          r_owner <= w_gnt[1];
          r_rw    <= w_gnt[1] ? r1_rw : r0_rw;
          r_addr  <= w_gnt[1] ? r1_addr : r0_addr;
          r_wdata <= w_gnt[1] ? r1_wdata : r0_wdata;
          r_size  <= size_t'(w_gnt[1] ? r1_size : r0_size);
          r_state <= ISSUE;
`ifdef UMEM_ARB_TIMEOUT_EN
          r_cnt   <= '0;
`endif
        end
      end else if (!r_mem_req) begin
        r_mem_req <= 1'b1;
      end else if (mem_ack) begin
        r_mem_req <= 1'b0;
        r_done    <= r_owner ? 2'b10 : 2'b01;
        r_rdata   <= r_rw ? '0 : mem_rdata;
        r_last    <= r_owner;
        r_state   <= IDLE;
`ifdef UMEM_ARB_TIMEOUT_EN
      end else if (r_cnt == CW'(TIMEOUT - 1)) begin
        r_mem_req <= 1'b0;
        r_done    <= r_owner ? 2'b10 : 2'b01;
        r_err     <= 1'b1;
        r_rdata   <= '0;
        r_last    <= r_owner;
        r_state   <= IDLE;
      end else begin
        r_cnt <= r_cnt + 1'b1;
`endif
      end
    end
  end
endmodule

// File: tb/tb_umem_arb.sv
// tb_umem_arb: directed self-checking bench for umem_arb
module tb_umem_arb;
  logic        clk, nreset;
  logic        r0_req, r0_rw, r1_req, r1_rw;
  logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
  logic [1:0]  r0_size, r1_size;
  logic        r0_gnt, r0_done, r0_err, r1_gnt, r1_done, r1_err;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_req, mem_rw, mem_ack;
  logic [1:0]  mem_size;
  int          errs = 0, checks = 0, cyc = 0;
  umem_arb #(.AW(32), .DW(32), .TIMEOUT(8)) dut (
    .clk(clk), .nreset(nreset),
    .r0_req(r0_req), .r0_rw(r0_rw), .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_size(r0_size),
    .r0_gnt(r0_gnt), .r0_done(r0_done), .r0_err(r0_err),
    .r1_req(r1_req), .r1_rw(r1_rw), .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_size(r1_size),
    .r1_gnt(r1_gnt), .r1_done(r1_done), .r1_err(r1_err),
    .rdata(rdata), .mem_req(mem_req), .mem_rw(mem_rw), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_size(mem_size), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, exp finish before 200000");
    $fatal(1, "watchdog");
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic apply_reset();
    nreset = 0;
    tick();
    tick();
    nreset = 1;
  endtask
  task automatic wait_gnt(output bit ok);
    int w = 0;
    while (!(r0_gnt | r1_gnt) && w < 10) begin
      tick();
      w++;
    end
    ok = (w < 10);
    checks++;
    if (!ok) begin
      errs++;
      $display("FAIL wait_gnt: got no grant, exp grant within 10 cycles");
    end
  endtask
  task automatic test_reset();
    {r0_req, r0_rw, r1_req, r1_rw, mem_ack} = '0;
    {r0_addr, r0_wdata, r1_addr, r1_wdata, mem_rdata} = '0;
    r0_size = 2'd0;
    r1_size = 2'd0;
    nreset = 0;
    #3;
    checks++;
    if ({r0_gnt, r1_gnt, r0_done, r1_done, r0_err, r1_err, rdata, mem_req, mem_rw, mem_addr, mem_wdata, mem_size} !== 0) begin
      errs++;
      $display("FAIL reset_outputs: got nonzero outputs, exp all zero");
    end
    tick();
    nreset = 1;
  endtask
  task automatic test_single_load();
    r0_req = 1; r0_rw = 0; r0_addr = 32'h10; r0_size = 2'd2;
    tick();
    checks++;
    if ({r0_gnt, r1_gnt, mem_req} !== 3'b100) begin errs++; $display("FAIL load_gnt: got %b exp 100", {r0_gnt, r1_gnt, mem_req}); end
    tick();
    checks++;
    if ({r0_gnt, mem_req, mem_rw, mem_addr, mem_size} !== {1'b0, 1'b1, 1'b0, 32'h10, 2'd2}) begin
      errs++; $display("FAIL load_issue: got req=%b addr=%h exp req=1 addr=10", mem_req, mem_addr);
    end
    mem_ack = 1; mem_rdata = 32'hDEADBEEF;
    tick();
    mem_ack = 0; r0_req = 0;
    checks++;
    if ({r0_done, r1_done, r0_err, mem_req} !== 4'b1000) begin errs++; $display("FAIL load_done: got %b exp 1000", {r0_done, r1_done, r0_err, mem_req}); end
    checks++;
    if (rdata !== 32'hDEADBEEF) begin errs++; $display("FAIL load_rdata: got %h exp deadbeef", rdata); end
    mem_rdata = 32'h0;
    tick();
    checks++;
    if ({r0_done, rdata} !== {1'b0, 32'hDEADBEEF}) begin errs++; $display("FAIL rdata_hold: got done=%b %h exp 0 deadbeef", r0_done, rdata); end
  endtask
  task automatic test_ack_outside();
    mem_ack = 1; mem_rdata = 32'h12345678;
    tick();
    tick();
    mem_ack = 0;
    checks++;
    if ({r0_done, r1_done, mem_req, rdata} !== {3'b000, 32'hDEADBEEF}) begin
      errs++; $display("FAIL ack_idle: got done=%b%b req=%b rdata=%h exp 000 deadbeef", r0_done, r1_done, mem_req, rdata);
    end
  endtask
  task automatic test_round_robin();
    bit ok;
    int last_g = -10;
    apply_reset();
    r0_rw = 0; r1_rw = 0; r0_addr = 32'h100; r1_addr = 32'h200;
    r0_req = 1; r1_req = 1;
    for (int k = 0; k < 6; k++) begin
      wait_gnt(ok);
      if (!ok) return;
      checks++;
      if ({r1_gnt, r0_gnt} !== ((k % 2) ? 2'b10 : 2'b01)) begin
        errs++; $display("FAIL rr_order%0d: got %b exp %b", k, {r1_gnt, r0_gnt}, (k % 2) ? 2'b10 : 2'b01);
      end
      if (k > 0) begin
        checks++;
        if (cyc - last_g < 3) begin errs++; $display("FAIL rr_gap%0d: got %0d exp >=3", k, cyc - last_g); end
      end
      last_g = cyc;
      tick();
      mem_ack = 1; mem_rdata = 32'hA0 + k;
      tick();
      mem_ack = 0;
      checks++;
      if ({r1_done, r0_done, rdata} !== {((k % 2) ? 2'b10 : 2'b01), 32'hA0 + k}) begin
        errs++; $display("FAIL rr_done%0d: got %b %h exp owner done rdata %h", k, {r1_done, r0_done}, rdata, 32'hA0 + k);
      end
      if (k % 2) r1_req = 0; else r0_req = 0;
      tick();
      checks++;
      if ({r0_gnt, r1_gnt} !== 2'b00) begin errs++; $display("FAIL rr_nogap%0d: got %b exp 00", k, {r0_gnt, r1_gnt}); end
      if (k % 2) r1_req = 1; else r0_req = 1;
    end
    tick();
    tick();
    r0_req = 0; r1_req = 0;
    apply_reset();
  endtask
  task automatic test_store_stall();
    bit ok;
    r1_req = 1; r1_rw = 1; r1_addr = 32'h3; r1_wdata = 32'hA5; r1_size = 2'd0;
    wait_gnt(ok);
    if (!ok) return;
    checks++;
    if ({r1_gnt, r0_gnt} !== 2'b10) begin errs++; $display("FAIL st_gnt: got %b exp 10", {r1_gnt, r0_gnt}); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({mem_req, mem_rw, mem_addr, mem_wdata, mem_size, r1_done} !== {2'b11, 32'h3, 32'hA5, 2'd0, 1'b0}) begin
        errs++; $display("FAIL st_hold%0d: got req=%b addr=%h wdata=%h size=%0d exp 1 3 a5 0", i, mem_req, mem_addr, mem_wdata, mem_size);
      end
    end
    mem_ack = 1; mem_rdata = 32'hFFFFFFFF;
    tick();
    mem_ack = 0; r1_req = 0;
    checks++;
    if ({r1_done, r0_done, r1_err, rdata} !== {3'b100, 32'h0}) begin
      errs++; $display("FAIL st_done: got done=%b err=%b rdata=%h exp 1 0 0", r1_done, r1_err, rdata);
    end
    tick();
  endtask
  task automatic test_reset_inflight();
    bit ok;
    r0_req = 1; r0_rw = 0; r0_addr = 32'h40; r0_size = 2'd2;
    wait_gnt(ok);
    tick();
    mem_ack = 1; mem_rdata = 32'h55;
    tick();
    mem_ack = 0; r0_req = 0;
    tick();
    r0_req = 1;
    wait_gnt(ok);
    tick();
    checks++;
    if (mem_req !== 1'b1) begin errs++; $display("FAIL rst_pre: got req=%b exp 1", mem_req); end
    #2 nreset = 0;
    #1;
    checks++;
    if ({r0_gnt, r1_gnt, r0_done, r1_done, r0_err, r1_err, rdata, mem_req, mem_rw, mem_addr, mem_wdata, mem_size} !== 0) begin
      errs++; $display("FAIL rst_async: got req=%b rdata=%h addr=%h exp all zero", mem_req, rdata, mem_addr);
    end
    r0_req = 0;
    tick();
    #2 nreset = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({r0_done, r1_done} !== 2'b00) begin errs++; $display("FAIL rst_nodone%0d: got %b exp 00", i, {r0_done, r1_done}); end
    end
    r0_req = 1; r1_req = 1;
    wait_gnt(ok);
    checks++;
    if ({r1_gnt, r0_gnt} !== 2'b01) begin errs++; $display("FAIL rst_prio: got %b exp 01", {r1_gnt, r0_gnt}); end
    r0_req = 0; r1_req = 0;
    apply_reset();
  endtask
  task automatic test_drop_req();
    bit ok;
    r1_req = 1; r1_rw = 0; r1_addr = 32'h80; r1_size = 2'd1;
    wait_gnt(ok);
    r1_req = 0;
    tick();
    checks++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h80}) begin errs++; $display("FAIL drop_issue: got %b %h exp 1 80", mem_req, mem_addr); end
    mem_ack = 1; mem_rdata = 32'h1234;
    tick();
    mem_ack = 0;
    checks++;
    if ({r1_done, r1_err, rdata} !== {2'b10, 32'h1234}) begin errs++; $display("FAIL drop_done: got %b %h exp 1 1234", r1_done, rdata); end
    tick();
  endtask
  task automatic test_timeout();
    bit ok;
    int n = 0;
    r0_req = 1; r0_rw = 0; r0_addr = 32'hC0; r0_size = 2'd2;
    wait_gnt(ok);
    tick();
    while (mem_req === 1'b1 && n < 20) begin
      n++;
      tick();
    end
`ifdef UMEM_ARB_TIMEOUT_EN
    checks++;
    if (n !== 8) begin errs++; $display("FAIL to_len: got %0d exp 8", n); end
    checks++;
    if ({r0_done, r0_err, rdata} !== {2'b11, 32'h0}) begin errs++; $display("FAIL to_done: got done=%b err=%b rdata=%h exp 1 1 0", r0_done, r0_err, rdata); end
`else
    checks++;
    if ({n, mem_req, r0_done} !== {32'd20, 2'b10}) begin errs++; $display("FAIL to_wait: got n=%0d req=%b done=%b exp 20 1 0", n, mem_req, r0_done); end
`endif
    r0_req = 0;
    apply_reset();
  endtask
  initial begin
    test_reset();
    test_single_load();
    test_ack_outside();
    test_round_robin();
    test_store_stall();
    test_reset_inflight();
    test_drop_req();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
